// File: rtl/mtimer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp, registered level irq.
// Optional MTIMER_SNAPSHOT_EN adds a shadow of mtime[63:32] latched on MTIME_LO reads.
module mtimer #(
    parameter int BASE_WADDR_W = 3,
    parameter int PRESC_W      = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    stb_i,
    input  logic [BASE_WADDR_W-1:0] adr_i,
    input  logic [3:0]              byte_sel_i,
    input  logic                    we_i,
    input  logic [31:0]             dat_i,
    output logic [31:0]             dat_o,
    output logic                    irq_o
);

    localparam logic [BASE_WADDR_W-1:0] A_MTIME_LO = BASE_WADDR_W'(0);
    localparam logic [BASE_WADDR_W-1:0] A_MTIME_HI = BASE_WADDR_W'(1);
    localparam logic [BASE_WADDR_W-1:0] A_CMP_LO   = BASE_WADDR_W'(2);
    localparam logic [BASE_WADDR_W-1:0] A_CMP_HI   = BASE_WADDR_W'(3);
    localparam logic [BASE_WADDR_W-1:0] A_CTRL     = BASE_WADDR_W'(4);
    localparam logic [BASE_WADDR_W-1:0] A_PRESC    = BASE_WADDR_W'(5);

    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp;
    logic               r_en;
    logic               r_ie;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pcnt;
    logic               r_irq;

    logic        w_wr;
    logic        w_rd;
    logic        w_pend;
    logic        w_tick;
    logic [31:0] w_wmask;
    logic [31:0] w_presc_ext;
    logic [31:0] w_rdata;
    logic [31:0] w_hi_rdata;

    assign w_wr        = stb_i && we_i;
    assign w_rd        = stb_i && !we_i;
    assign w_pend      = (r_mtime >= r_mtimecmp);
    assign w_tick      = r_en && (r_pcnt == r_presc);
    assign w_wmask     = {{8{byte_sel_i[3]}}, {8{byte_sel_i[2]}},
                          {8{byte_sel_i[1]}}, {8{byte_sel_i[0]}}};
    assign w_presc_ext = 32'(r_presc);

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [31:0] mask);
        return (oldVal & ~mask) | (newVal & mask);
    endfunction

    // A bus write to either mtime half takes priority over that cycle's increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mtime <= '0;
        end else if (w_wr && adr_i == A_MTIME_LO) begin
            r_mtime[31:0] <= mergeBytes(r_mtime[31:0], dat_i, w_wmask);
        end else if (w_wr && adr_i == A_MTIME_HI) begin
            r_mtime[63:32] <= mergeBytes(r_mtime[63:32], dat_i, w_wmask);
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pcnt <= '0;
        end else if (w_wr && (adr_i == A_CTRL || adr_i == A_PRESC)) begin
            r_pcnt <= '0;
        end else if (!r_en || r_pcnt == r_presc) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mtimecmp <= '1;
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_presc    <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= r_ie && w_pend;
            if (w_wr) begin
                case (adr_i)
                    A_CMP_LO: r_mtimecmp[31:0]  <= mergeBytes(r_mtimecmp[31:0], dat_i, w_wmask);
                    A_CMP_HI: r_mtimecmp[63:32] <= mergeBytes(r_mtimecmp[63:32], dat_i, w_wmask);
                    A_CTRL: begin
                        if (byte_sel_i[0]) begin
                            r_en <= dat_i[0];
                            r_ie <= dat_i[1];
                        end
                    end
                    A_PRESC: r_presc <= PRESC_W'(mergeBytes(w_presc_ext, dat_i, w_wmask));
                    default: ;
                endcase
            end
        end
    end

`ifdef MTIMER_SNAPSHOT_EN
    logic [31:0] r_shadow;

    // Latching HI on a LO read gives software a coherent LO-then-HI pair.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shadow <= '0;
        end else if (w_rd && adr_i == A_MTIME_LO) begin
            r_shadow <= r_mtime[63:32];
        end else if (w_wr && adr_i == A_MTIME_HI) begin
            r_shadow <= mergeBytes(r_shadow, dat_i, w_wmask);
        end
    end

    assign w_hi_rdata = r_shadow;
`else
    assign w_hi_rdata = r_mtime[63:32];
`endif

    always_comb begin
        w_rdata = '0;
        case (adr_i)
            A_MTIME_LO: w_rdata = r_mtime[31:0];
            A_MTIME_HI: w_rdata = w_hi_rdata;
            A_CMP_LO:   w_rdata = r_mtimecmp[31:0];
            A_CMP_HI:   w_rdata = r_mtimecmp[63:32];
            A_CTRL:     w_rdata = {29'd0, w_pend, r_ie, r_en};
            A_PRESC:    w_rdata = w_presc_ext;
            default:    w_rdata = '0;
        endcase
    end

    assign dat_o = (rst_ni && w_rd) ? w_rdata : 32'd0;
    assign irq_o = r_irq;

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer: directed scenarios with literal expectations plus
// randomized bus traffic compared every cycle against a behavioural timer model.
module tb_mtimer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        stb_i = 1'b0;
    logic [2:0]  adr_i = '0;
    logic [3:0]  byte_sel_i = '0;
    logic        we_i = 1'b0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        irq_o;

    int nCompared = 0;
    int nFailed = 0;
    bit checkOn = 1'b0;

    always #5 clk_i = ~clk_i;

    mtimer dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .stb_i      (stb_i),
        .adr_i      (adr_i),
        .byte_sel_i (byte_sel_i),
        .we_i       (we_i),
        .dat_i      (dat_i),
        .dat_o      (dat_o),
        .irq_o      (irq_o)
    );

    // Behavioural model: timer state as plain integers.
    longint unsigned mMtime = 0;
    longint unsigned mCmp = 64'hFFFF_FFFF_FFFF_FFFF;
    bit              mEn = 0;
    bit              mIe = 0;
    int unsigned     mPresc = 0;
    int unsigned     mPcnt = 0;
    bit              mIrq = 0;
    bit [31:0]       mShadow = 0;

    function automatic bit [31:0] mergeWord(input bit [31:0] oldVal, input bit [31:0] newVal,
                                            input bit [3:0] lanes);
        bit [31:0] res = oldVal;
        for (int n = 0; n < 4; n++)
            if (lanes[n]) res[8*n +: 8] = newVal[8*n +: 8];
        return res;
    endfunction

    function automatic bit [31:0] modelRead();
        bit [63:0] t = mMtime;
        bit [63:0] c = mCmp;
        if (!rst_ni || !stb_i || we_i) return 32'd0;
        case (adr_i)
            3'd0: return t[31:0];
`ifdef MTIMER_SNAPSHOT_EN
            3'd1: return mShadow;
`else
            3'd1: return t[63:32];
`endif
            3'd2: return c[31:0];
            3'd3: return c[63:32];
            3'd4: return {29'd0, (mMtime >= mCmp), mIe, mEn};
            3'd5: return mPresc;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin : modelStep
        bit [63:0]       t;
        bit [63:0]       c;
        longint unsigned nMtime;
        int unsigned     nPcnt;
        if (!rst_ni) begin
            mMtime = 0; mCmp = 64'hFFFF_FFFF_FFFF_FFFF; mEn = 0; mIe = 0;
            mPresc = 0; mPcnt = 0; mIrq = 0; mShadow = 0;
        end else begin
            t = mMtime;
            c = mCmp;
            nMtime = mMtime;
            nPcnt = 0;
            if (mEn) begin
                if (mPcnt == mPresc) nMtime = mMtime + 1;
                else nPcnt = mPcnt + 1;
            end
            mIrq = mIe && (mMtime >= mCmp);
`ifdef MTIMER_SNAPSHOT_EN
            if (stb_i && !we_i && adr_i == 3'd0) mShadow = t[63:32];
            if (stb_i && we_i && adr_i == 3'd1) mShadow = mergeWord(mShadow, dat_i, byte_sel_i);
`endif
            if (stb_i && we_i) begin
                case (adr_i)
                    3'd0: nMtime = {t[63:32], mergeWord(t[31:0], dat_i, byte_sel_i)};
                    3'd1: nMtime = {mergeWord(t[63:32], dat_i, byte_sel_i), t[31:0]};
                    3'd2: mCmp = {c[63:32], mergeWord(c[31:0], dat_i, byte_sel_i)};
                    3'd3: mCmp = {mergeWord(c[63:32], dat_i, byte_sel_i), c[31:0]};
                    3'd4: begin
                        if (byte_sel_i[0]) begin
                            mEn = dat_i[0];
                            mIe = dat_i[1];
                        end
                        nPcnt = 0;
                    end
                    3'd5: begin
                        mPresc = mergeWord(mPresc, dat_i, byte_sel_i) & 32'h0000_FFFF;
                        nPcnt = 0;
                    end
                    default: ;
                endcase
            end
            mMtime = nMtime;
            mPcnt = nPcnt;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled mid-period.
    always @(negedge clk_i) begin
        if (checkOn) begin
            checkOutput("model dat_o", dat_o, modelRead());
            checkOutput("model irq_o", {31'd0, irq_o}, {31'd0, mIrq});
        end
    end

    task automatic applyStimulus(input bit stb, input bit we, input bit [2:0] adr,
                                 input bit [3:0] bs, input bit [31:0] dat);
        stb_i = stb; we_i = we; adr_i = adr; byte_sel_i = bs; dat_i = dat;
        @(posedge clk_i);
        #1;
        stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic writeReg(input bit [2:0] adr, input bit [31:0] dat);
        applyStimulus(1'b1, 1'b1, adr, 4'hF, dat);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'd0);
    endtask

    task automatic readExpect(input string name, input bit [2:0] adr, input bit [31:0] exp);
        stb_i = 1'b1; we_i = 1'b0; adr_i = adr; byte_sel_i = 4'h0;
        @(negedge clk_i);
        checkOutput(name, dat_o, exp);
        @(posedge clk_i);
        #1;
        stb_i = 1'b0;
    endtask

    task automatic irqExpect(input string name, input bit exp);
        checkOutput(name, {31'd0, irq_o}, {31'd0, exp});
    endtask

    task automatic checkResetMap();
        bit [31:0] expVals [8] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        irqExpect("reset irq", 1'b0);
        for (int a = 0; a < 8; a++)
            readExpect($sformatf("reset addr%0d", a), 3'(a), expVals[a]);
    endtask

    initial begin
        #12;
        rst_ni = 1'b1;
        checkOn = 1'b1;
        @(posedge clk_i);
        #1;

        checkResetMap();

        // Prescaler 3: one increment per four cycles.
        writeReg(3'd5, 32'd3);
        writeReg(3'd4, 32'd1);
        idle(40);
        readExpect("presc3 mtime_lo", 3'd0, 32'd10);

        // Low-to-high carry as a single 64-bit add.
        writeReg(3'd4, 32'd0);
        writeReg(3'd5, 32'd0);
        writeReg(3'd1, 32'd0);
        writeReg(3'd0, 32'hFFFF_FFFF);
        writeReg(3'd4, 32'd1);
        writeReg(3'd4, 32'd0);
        readExpect("wrap lo", 3'd0, 32'd0);
        readExpect("wrap hi", 3'd1, 32'd1);

        // Compare match and release.
        writeReg(3'd0, 32'd0);
        writeReg(3'd1, 32'd0);
        writeReg(3'd3, 32'd0);
        writeReg(3'd2, 32'd20);
        writeReg(3'd4, 32'd3);
        idle(19);
        irqExpect("irq before match", 1'b0);
        idle(1);
        irqExpect("irq at match edge", 1'b0);
        idle(1);
        irqExpect("irq after match", 1'b1);
        writeReg(3'd2, 32'd100);
        irqExpect("irq at cmp write", 1'b1);
        idle(1);
        irqExpect("irq after cmp raise", 1'b0);
        readExpect("ctrl no pend", 3'd4, 32'd3);

        // Partial-lane write to MTIME_LO while counting.
        writeReg(3'd4, 32'd0);
        writeReg(3'd1, 32'd0);
        writeReg(3'd0, 32'h1234_5678);
        writeReg(3'd4, 32'd1);
        applyStimulus(1'b1, 1'b1, 3'd0, 4'b0010, 32'h0000_AB00);
        readExpect("byte lane write", 3'd0, 32'h1234_AB78);

        // Asynchronous reset while the interrupt is asserted.
        writeReg(3'd4, 32'd3);
        idle(2);
        irqExpect("irq before reset", 1'b1);
        stb_i = 1'b1; we_i = 1'b0; adr_i = 3'd2;
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("async reset dat_o", dat_o, 32'd0);
        checkOutput("async reset irq_o", {31'd0, irq_o}, 32'd0);
        @(negedge clk_i);
        #2;
        stb_i = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        checkResetMap();

        // Randomized bus traffic checked by the model each cycle.
        for (int i = 0; i < 800; i++) begin
            bit        stb = ($urandom_range(0, 99) < 70);
            bit        we = $urandom_range(0, 1);
            bit [2:0]  adr = 3'($urandom_range(0, 7));
            bit [3:0]  bs = 4'($urandom);
            bit [31:0] dat = $urandom;
            if (adr == 3'd5) dat = $urandom_range(0, 3);
            if (adr == 3'd4) dat = {30'd0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0)};
            if ((adr == 3'd0 || adr == 3'd2) && $urandom_range(0, 3) == 0) dat = 32'hFFFF_FFF0;
            if ((adr == 3'd1 || adr == 3'd3) && $urandom_range(0, 1) == 0) dat = $urandom_range(0, 1);
            applyStimulus(stb, we, adr, bs, dat);
        end

        idle(2);
        checkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
